// File: rtl/isc_insn_encoder.sv
`default_nettype none
// ==== isc_insn_encoder : packs decoded descriptors into PE_INST_W-bit HPU instruction words ====
// ==== rev 1.0 ===================================================================================

package isc_insn_pkg;
  localparam int PE_INST_W = 32;
  localparam int PAYLOAD_W = PE_INST_W - 2;
  localparam int RID_W     = 7;
  localparam int CID_W     = 16;
  localparam int MASK_W    = 8;
  localparam int DOP_W     = 5;
  localparam int LUT_W     = 4;

  typedef enum logic [2:0] {
    ARITH  = 3'd0,
    SYNC   = 3'd1,
    MEM_LD = 3'd2,
    MEM_ST = 3'd3,
    PBS    = 3'd4
  } insn_kind_e;

  typedef enum logic [1:0] {
    REGISTER = 2'd0,
    MEMORY   = 2'd1
  } insn_mode_e;

  localparam logic [DOP_W-1:0] DOP_ADD  = 5'd0;
  localparam logic [DOP_W-1:0] DOP_SUB  = 5'd1;
  localparam logic [DOP_W-1:0] DOP_MAC  = 5'd2;
  localparam logic [DOP_W-1:0] DOP_ADDS = 5'd3;
  localparam logic [DOP_W-1:0] DOP_SUBS = 5'd4;
  localparam logic [DOP_W-1:0] DOP_SSUB = 5'd5;
  localparam logic [DOP_W-1:0] DOP_MULS = 5'd6;

  typedef struct packed {
    insn_mode_e        mode;
    logic [RID_W-1:0]  id;
  } insn_id_t;

  typedef struct packed {
    insn_id_t          isc;
    logic [MASK_W-1:0] mask;
  } dstn_id_t;

  typedef struct packed {
    insn_kind_e        kind;
    logic [DOP_W-1:0]  dop;
    dstn_id_t          dst;
    insn_id_t          src_a;
    insn_id_t          src_b;
    logic              flush;
  } insn_desc_t;

  typedef struct packed {
    logic [3:0]        mul_factor;
    logic [RID_W-1:0]  src1_rid;
    logic [RID_W-1:0]  src0_rid;
    logic [RID_W-1:0]  dst_rid;
    logic [DOP_W-1:0]  dop;
  } pea_mac_inst_t;

  typedef struct packed {
    logic [CID_W-1:0]  cid;
    logic [RID_W-1:0]  rid;
    logic [6:0]        dop;
  } pem_inst_t;

  typedef struct packed {
    logic              flush_pbs;
    logic [LUT_W-1:0]  log_lut_nb;
  } pep_dop_t;

  typedef struct packed {
    logic [10:0]       gid;
    logic [RID_W-1:0]  src0_rid;
    logic [RID_W-1:0]  dst_rid;
    pep_dop_t          dop;
  } pep_inst_t;
endpackage

module isc_insn_encoder
  import isc_insn_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  insn_kind_e           in_kind,
  input  logic [DOP_W-1:0]     in_dop,
  input  dstn_id_t             in_dst,
  input  insn_id_t             in_srcA,
  input  insn_id_t             in_srcB,
  input  logic                 in_flush,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PE_INST_W-1:0] out_insn,
  output logic                 err,
  output logic [2:0]           err_code,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     cnt_arith,
  output logic [CNT_W-1:0]     cnt_sync,
  output logic [CNT_W-1:0]     cnt_mem,
  output logic [CNT_W-1:0]     cnt_pbs
);

  insn_desc_t             s1_q, s1_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [1:0]             fcnt_q, fcnt_d;
  logic [PE_INST_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic                   err_q, err_d;
  logic [2:0]             code_q, code_d;
  logic [CNT_W-1:0]       arith_q, arith_d, sync_q, sync_d, mem_q, mem_d, pbs_q, pbs_d;

  logic [MASK_W-1:0]      w_mask_m1;
  logic                   w_mask_shl;
  logic                   w_mask_ones;
  logic                   w_dop3;
  logic                   w_mode_bad;
  logic [2:0]             w_chk;
  logic [LUT_W-1:0]       w_lut_nb;
  logic [PE_INST_W-1:0]   w_word;
  logic                   w_pop;
  logic                   w_drain;
  logic                   w_push;
  pea_mac_inst_t          w_mac;
  pem_inst_t              w_mem;
  pep_inst_t              w_pep;

  // A legal PBS mask is a contiguous run of ones reaching the MSB; zero is never legal.
  assign w_mask_m1   = s1_q.dst.mask - 1'b1;
  assign w_mask_shl  = (s1_q.dst.mask != '0) && ((s1_q.dst.mask | w_mask_m1) == '1);
  assign w_mask_ones = (s1_q.dst.mask == '1);
  assign w_dop3      = (s1_q.dop == DOP_ADD) || (s1_q.dop == DOP_SUB) || (s1_q.dop == DOP_MAC);

  always_comb begin
    w_lut_nb = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (s1_q.dst.mask[i]) w_lut_nb = LUT_W'(i);
    end
  end

  always_comb begin
    w_mode_bad = 1'b0;
    case (s1_q.kind)
      MEM_LD:     w_mode_bad = (s1_q.dst.isc.mode != REGISTER) || (s1_q.src_a.mode != MEMORY);
      MEM_ST:     w_mode_bad = (s1_q.dst.isc.mode != MEMORY)   || (s1_q.src_a.mode != REGISTER);
      ARITH, PBS: w_mode_bad = (s1_q.dst.isc.mode != REGISTER) || (s1_q.src_a.mode != REGISTER);
      default:    w_mode_bad = 1'b0;
    endcase
  end

  // Checks are applied highest code first so the lowest failing code is the one kept.
  always_comb begin
    w_chk = 3'd0;
    if (s1_q.flush && (s1_q.kind != PBS)) w_chk = 3'd4;
    if ((s1_q.kind == ARITH) && w_dop3 && (s1_q.src_b.mode != REGISTER)) w_chk = 3'd3;
    if (w_mode_bad) w_chk = 3'd2;
    if ((s1_q.kind == PBS) ? !w_mask_shl : !w_mask_ones) w_chk = 3'd1;
  end

  always_comb begin
    w_mac  = '0;
    w_mem  = '0;
    w_pep  = '0;
    w_word = '0;
    case (s1_q.kind)
      ARITH: begin
        w_mac.dop      = s1_q.dop;
        w_mac.dst_rid  = s1_q.dst.isc.id;
        w_mac.src0_rid = s1_q.src_a.id;
        if (w_dop3) w_mac.src1_rid = s1_q.src_b.id;
        w_word = {2'b00, w_mac};
      end
      SYNC: w_word = {2'b01, {PAYLOAD_W{1'b0}}};
      MEM_LD: begin
        w_mem.dop[0] = 1'b0;
        w_mem.rid    = s1_q.dst.isc.id;
        w_mem.cid    = CID_W'(s1_q.src_a.id);
        w_word = {2'b10, w_mem};
      end
      MEM_ST: begin
        w_mem.dop[0] = 1'b1;
        w_mem.rid    = s1_q.src_a.id;
        w_mem.cid    = CID_W'(s1_q.dst.isc.id);
        w_word = {2'b10, w_mem};
      end
      PBS: begin
        w_pep.dst_rid        = s1_q.dst.isc.id;
        w_pep.src0_rid       = s1_q.src_a.id;
        w_pep.dop.flush_pbs  = s1_q.flush;
        w_pep.dop.log_lut_nb = w_lut_nb;
        w_word = {2'b11, w_pep};
      end
      default: w_word = '0;
    endcase
  end

  // Errored entries leave s1 unconditionally since they never occupy a FIFO slot.
  assign w_pop   = out_rdy && (fcnt_q != 2'd0);
  assign w_drain = s1_vld_q && ((w_chk != 3'd0) || (fcnt_q != 2'd2) || w_pop);
  assign w_push  = w_drain && (w_chk == 3'd0);
  assign in_rdy  = !s1_vld_q || w_drain;

  always_comb begin
    s1_vld_d = (in_vld && in_rdy) || (s1_vld_q && !w_drain);
    s1_d     = s1_q;
    if (in_vld && in_rdy) begin
      s1_d.kind  = in_kind;
      s1_d.dop   = in_dop;
      s1_d.dst   = in_dst;
      s1_d.src_a = in_srcA;
      s1_d.src_b = in_srcB;
      s1_d.flush = in_flush;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fcnt_d = fcnt_q;
    case ({w_push, w_pop})
      2'b10: begin
        if (fcnt_q == 2'd0) head_d = w_word;
        else                tail_d = w_word;
        fcnt_d = fcnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        fcnt_d = fcnt_q - 2'd1;
      end
      2'b11: begin
        if (fcnt_q == 2'd1) begin
          head_d = w_word;
        end else begin
          head_d = tail_q;
          tail_d = w_word;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (err_clr) begin
      err_d  = 1'b0;
      code_d = 3'd0;
    end else if (s1_vld_q && (w_chk != 3'd0)) begin
      err_d = 1'b1;
      if (!err_q) code_d = w_chk;
    end
  end

  always_comb begin
    arith_d = arith_q;
    sync_d  = sync_q;
    mem_d   = mem_q;
    pbs_d   = pbs_q;
    if (w_push) begin
      case (s1_q.kind)
        ARITH:          arith_d = arith_q + 1'b1;
        SYNC:           sync_d  = sync_q + 1'b1;
        MEM_LD, MEM_ST: mem_d   = mem_q + 1'b1;
        PBS:            pbs_d   = pbs_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      fcnt_q   <= 2'd0;
      head_q   <= '0;
      tail_q   <= '0;
      err_q    <= 1'b0;
      code_q   <= 3'd0;
      arith_q  <= '0;
      sync_q   <= '0;
      mem_q    <= '0;
      pbs_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      fcnt_q   <= fcnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      err_q    <= err_d;
      code_q   <= code_d;
      arith_q  <= arith_d;
      sync_q   <= sync_d;
      mem_q    <= mem_d;
      pbs_q    <= pbs_d;
    end
  end

  assign out_vld   = (fcnt_q != 2'd0);
  assign out_insn  = head_q;
  assign err       = err_q;
  assign err_code  = code_q;
  assign cnt_arith = arith_q;
  assign cnt_sync  = sync_q;
  assign cnt_mem   = mem_q;
  assign cnt_pbs   = pbs_q;

endmodule

`default_nettype wire
